// File: rtl/npuarc_biu_defines.sv
// Shared BIU definitions: command-gate FSM state encoding and outstanding-limit default.
package npuarc_biu_defines;

  typedef enum logic [1:0] {
    BIU_ST_RUN   = 2'd0,
    BIU_ST_DRAIN = 2'd1,
    BIU_ST_HALT  = 2'd2
  } biu_gate_state_e;

  localparam int BIU_OUTSTAND_NUM = 16;

endpackage

// File: rtl/npuarc_biu_preprc_ibp_outstd_cnt.sv
// Saturating-at-zero outstanding transaction counter; simultaneous inc and dec hold the value.
module npuarc_biu_preprc_ibp_outstd_cnt #(
  parameter int CNT_W   = 4,
  parameter int MAX_NUM = 16
) (
  input  logic           clk,
  input  logic           rst_a,
  input  logic           clr,
  input  logic           inc,
  input  logic           dec,
  output logic [CNT_W:0] cnt,
  output logic           full,
  output logic           zero
);

  localparam logic [CNT_W:0] MAX_V = (CNT_W+1)'(MAX_NUM);

  logic [CNT_W:0] cnt_r;

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc && !dec) begin
      cnt_r <= cnt_r + 1'b1;
    end else if (dec && !inc && (cnt_r != '0)) begin
      cnt_r <= cnt_r - 1'b1;
    end
  end

  assign cnt  = cnt_r;
  assign full = (cnt_r == MAX_V);
  assign zero = (cnt_r == '0);

endmodule

// File: rtl/npuarc_biu_preprc_ibp_cmd_gate.sv
// IBP command gate: limits outstanding reads/writes and quiesces the command path on drain request.
module npuarc_biu_preprc_ibp_cmd_gate
  import npuarc_biu_defines::*;
#(
  parameter int CMD_CHNL_W      = 49,
  parameter int CMD_CHNL_READ   = 0,
  parameter int RD_CHNL_W       = 35,
  parameter int RD_CHNL_RD_LAST = 1,
  parameter int OUTSTAND_CNT_W  = 4,
  parameter int OUTSTAND_NUM    = BIU_OUTSTAND_NUM
) (
  input  logic                  clk,
  input  logic                  rst_a,
  input  logic                  nmi_restart_r,
  input  logic                  i_ibp_cmd_chnl_valid,
  output logic                  i_ibp_cmd_chnl_accept,
  input  logic [CMD_CHNL_W-1:0] i_ibp_cmd_chnl,
  output logic                  o_ibp_cmd_chnl_valid,
  input  logic                  o_ibp_cmd_chnl_accept,
  output logic [CMD_CHNL_W-1:0] o_ibp_cmd_chnl,
  input  logic                  ibp_rd_chnl_valid,
  input  logic                  ibp_rd_chnl_accept,
  input  logic [RD_CHNL_W-1:0]  ibp_rd_chnl,
  input  logic                  ibp_wrsp_chnl_valid,
  input  logic                  ibp_wrsp_chnl_accept,
  input  logic                  drain_req,
  output logic                  drain_ack,
  output logic                  o_ibp_idle
);

  biu_gate_state_e state_r, state_next;
  logic            drain_ack_r;
  logic            cmd_is_rd, block, cmd_hs;
  logic            rd_inc, rd_dec, wr_inc, wr_dec;
  logic            rd_full, wr_full, rd_zero, wr_zero;
  logic [OUTSTAND_CNT_W:0] rd_cnt, wr_cnt;

  assign o_ibp_cmd_chnl = i_ibp_cmd_chnl;
  assign cmd_is_rd      = i_ibp_cmd_chnl[CMD_CHNL_READ];

  // Block depends only on state, counters and the command bundle, so valid and accept stay independent.
  assign block = (state_r != BIU_ST_RUN) | (cmd_is_rd & rd_full) | (~cmd_is_rd & wr_full);

  assign o_ibp_cmd_chnl_valid  = i_ibp_cmd_chnl_valid  & ~block;
  assign i_ibp_cmd_chnl_accept = o_ibp_cmd_chnl_accept & ~block;

  assign cmd_hs = o_ibp_cmd_chnl_valid & o_ibp_cmd_chnl_accept;
  assign rd_inc = cmd_hs & cmd_is_rd;
  assign wr_inc = cmd_hs & ~cmd_is_rd;
  assign rd_dec = ibp_rd_chnl_valid & ibp_rd_chnl_accept & ibp_rd_chnl[RD_CHNL_RD_LAST];
  assign wr_dec = ibp_wrsp_chnl_valid & ibp_wrsp_chnl_accept;

  npuarc_biu_preprc_ibp_outstd_cnt #(
    .CNT_W   (OUTSTAND_CNT_W),
    .MAX_NUM (OUTSTAND_NUM)
  ) u_rd_cnt (
    .clk   (clk),
    .rst_a (rst_a),
    .clr   (nmi_restart_r),
    .inc   (rd_inc),
    .dec   (rd_dec),
    .cnt   (rd_cnt),
    .full  (rd_full),
    .zero  (rd_zero)
  );

  npuarc_biu_preprc_ibp_outstd_cnt #(
    .CNT_W   (OUTSTAND_CNT_W),
    .MAX_NUM (OUTSTAND_NUM)
  ) u_wr_cnt (
    .clk   (clk),
    .rst_a (rst_a),
    .clr   (nmi_restart_r),
    .inc   (wr_inc),
    .dec   (wr_dec),
    .cnt   (wr_cnt),
    .full  (wr_full),
    .zero  (wr_zero)
  );

  assign o_ibp_idle = rd_zero & wr_zero;

  always_comb begin
    state_next = state_r;
    case (state_r)
      BIU_ST_RUN:   if (drain_req) state_next = BIU_ST_DRAIN;
      BIU_ST_DRAIN: begin
        if (!drain_req)      state_next = BIU_ST_RUN;
        else if (o_ibp_idle) state_next = BIU_ST_HALT;
      end
      BIU_ST_HALT:  if (!drain_req) state_next = BIU_ST_RUN;
      default:      state_next = BIU_ST_RUN;
    endcase
    if (nmi_restart_r) state_next = BIU_ST_RUN;
  end

  // drain_ack is its own flop tracking the HALT state, so it never glitches.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state_r     <= BIU_ST_RUN;
      drain_ack_r <= 1'b0;
    end else begin
      state_r     <= state_next;
      drain_ack_r <= (state_next == BIU_ST_HALT);
    end
  end

  assign drain_ack = drain_ack_r;

endmodule
